// File: rtl/l2_block_bridge_pkg.sv
// Shared bus types for the coherence controller's L2 port and the block bridge FSM encoding.
package l2_block_bridge_pkg;

    typedef enum logic [1:0] {
        L2_FREE   = 2'd0,
        L2_BUSY   = 2'd1,
        L2_ACCESS = 2'd2,
        L2_ERROR  = 2'd3
    } l2_state_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_XFER   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    function automatic l2_state_t state_to_l2(input logic [1:0] st);
        l2_state_t s;
        case (st)
            ST_IDLE:   s = L2_FREE;
            ST_XFER:   s = L2_BUSY;
            ST_ACCESS: s = L2_ACCESS;
            default:   s = L2_ERROR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating busy-cycle counter; flags the stalled cycle that brings the count to TIMEOUT.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 25
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_W'(TIMEOUT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Combinational so the owner can leave on the same edge the count hits TIMEOUT.
    assign o_expired = i_inc && (r_count >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/l2_block_bridge.sv
// Serialises block-granular L2 loads/stores into single-word memory bus transactions.
module l2_block_bridge
    import l2_block_bridge_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE_WORDS = 2,
    parameter int unsigned WORD_W           = 32,
    parameter int unsigned ADDR_W           = 32,
    parameter int unsigned TIMEOUT          = 25
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               l2_load,
    input  logic                               l2_store,
    input  logic [ADDR_W-1:0]                  l2_addr,
    input  logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_store_value,
    output logic [BLOCK_SIZE_WORDS*WORD_W-1:0] l2_load_value,
    output l2_state_t                          l2_state,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [WORD_W-1:0]                  mem_wdata,
    output logic                               mem_ren,
    output logic                               mem_wen,
    output logic [WORD_W/8-1:0]                mem_byte_en,
    input  logic [WORD_W-1:0]                  mem_rdata,
    input  logic                               mem_busy
);

    localparam int unsigned BYTES_PER_WORD = WORD_W / 8;
    localparam int unsigned BLOCK_BYTES    = BLOCK_SIZE_WORDS * BYTES_PER_WORD;
    localparam int unsigned OFFSET_W       = $clog2(BLOCK_BYTES);
    localparam int unsigned IDX_W          = (BLOCK_SIZE_WORDS > 1) ? $clog2(BLOCK_SIZE_WORDS) : 1;
    localparam int unsigned BYTE_SHIFT     = $clog2(BYTES_PER_WORD);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BLOCK_SIZE_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFFSET_W;

    logic [1:0]                               r_state;
    logic [1:0]                               w_state_d;
    logic                                     r_op_load;
    logic [ADDR_W-1:0]                        r_base;
    logic [IDX_W-1:0]                         r_idx;
    logic [BLOCK_SIZE_WORDS-1:0][WORD_W-1:0]  r_wblk;
    logic [BLOCK_SIZE_WORDS-1:0][WORD_W-1:0]  r_lbuf;

    logic w_xfer;
    logic w_done;
    logic w_stall;
    logic w_last;
    logic w_accept;
    logic w_req_held;
    logic w_wd_expired;

    assign w_xfer     = (r_state == ST_XFER);
    assign w_done     = w_xfer && !mem_busy;
    assign w_stall    = w_xfer && mem_busy;
    assign w_last     = (r_idx == LAST_IDX);
    assign w_accept   = (r_state == ST_IDLE) && (l2_load ^ l2_store);
    assign w_req_held = r_op_load ? l2_load : l2_store;

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_clr     (w_accept || w_done),
        .i_inc     (w_stall),
        .o_expired (w_wd_expired)
    );

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: begin
                if (l2_load && l2_store) begin
                    w_state_d = ST_ERROR;
                end else if (l2_load || l2_store) begin
                    w_state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (w_done && w_last) begin
                    w_state_d = ST_ACCESS;
                end else if (w_wd_expired) begin
                    w_state_d = ST_ERROR;
                end
            end
            // 4-phase handshake: wait for the controller to drop the line we served.
            ST_ACCESS: begin
                if (!w_req_held) begin
                    w_state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (!l2_load && !l2_store) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= ST_IDLE;
            r_op_load <= 1'b0;
            r_base    <= '0;
            r_idx     <= '0;
            r_wblk    <= '0;
            r_lbuf    <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_op_load <= l2_load;
                r_base    <= l2_addr & BASE_MASK;
                r_wblk    <= l2_store_value;
                r_idx     <= '0;
            end
            if (w_done) begin
                if (r_op_load) begin
                    r_lbuf[r_idx] <= mem_rdata;
                end
                if (!w_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    // Base is block aligned, so OR-ing in the word offset never carries out of the block.
    assign mem_addr      = r_base | (ADDR_W'(r_idx) << BYTE_SHIFT);
    assign mem_wdata     = r_wblk[r_idx];
    assign mem_ren       = w_xfer && r_op_load;
    assign mem_wen       = w_xfer && !r_op_load;
    assign mem_byte_en   = {BYTES_PER_WORD{mem_ren || mem_wen}};
    assign l2_load_value = r_lbuf;
    assign l2_state      = state_to_l2(r_state);

endmodule

// File: doc/l2_block_bridge.md
# l2_block_bridge

Downstream neighbour of the coherence bus controller. Accepts block-granular L2 load/store requests (BLOCK_SIZE_WORDS words per block) on the controller's L2 port and serialises them into single-word transactions on a generic memory bus toward L2/main memory. For loads it gathers the returned words into a block. It reports progress back to the controller through the L2 state encoding, and has a watchdog that turns a hung memory bus into an error.

## Interface
Parameters:
- BLOCK_SIZE_WORDS, 2, words per cache block; power of two, ≥1
- WORD_W, 32, word and data-bus width
- ADDR_W, 32, address width
- TIMEOUT, 25, max consecutive busy cycles per word before error; ≥1

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- l2_load  in  1  block read request, level
- l2_store  in  1  block write request, level
- l2_addr  in  ADDR_W  block address; low log2(BLOCK_SIZE_WORDS*WORD_W/8) bits ignored
- l2_store_value  in  BLOCK_SIZE_WORDS*WORD_W  store block, word 0 in LSBs
- l2_load_value  out  BLOCK_SIZE_WORDS*WORD_W  load block, word 0 in LSBs
- l2_state  out  l2_state_t  L2_FREE / L2_BUSY / L2_ACCESS / L2_ERROR
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  WORD_W  write data
- mem_ren  out  1  word read strobe
- mem_wen  out  1  word write strobe
- mem_byte_en  out  WORD_W/8  byte enables, all ones while ren/wen is high, else 0
- mem_rdata  in  WORD_W  read data, valid when busy is low
- mem_busy  in  1  memory stall; a word completes in any cycle where ren/wen is high and busy is low

## Operation
- FSM states: IDLE, XFER, ACCESS, ERROR.
- l2_state mapping: IDLE→L2_FREE, XFER→L2_BUSY, ACCESS→L2_ACCESS, ERROR→L2_ERROR.
- IDLE, exactly one of load/store high:
  - latch op, aligned base address and l2_store_value
  - clear word index and watchdog
  - go to XFER
- IDLE, load and store both high: go to ERROR. No memory access is issued.
- XFER:
  - mem_ren = op==load; mem_wen = op==store
  - mem_addr = base + index*(WORD_W/8); mem_wdata = latched word[index]
  - On completion:
    - load: write mem_rdata into load buffer word[index]
    - clear watchdog
    - if index == BLOCK_SIZE_WORDS-1, go to ACCESS; else index+1
  - Busy cycle: watchdog+1. When the watchdog reaches TIMEOUT, go to ERROR.
- The request lines are ignored during XFER; they may drop early with no effect.
- ACCESS: held while the latched request line is still high; go to IDLE the cycle after it is low (4-phase handshake).
- ERROR: held until l2_load and l2_store are both low, then IDLE. The load buffer is undefined after an error.
- l2_load_value drives the load buffer at all times. It is guaranteed valid only in ACCESS after a load. The buffer is not cleared between transactions.
- The index never exceeds BLOCK_SIZE_WORDS-1, and address arithmetic never carries out of the block.

## Timing
- Reset values: state IDLE, l2_state L2_FREE, mem_ren/wen 0, mem_byte_en 0, mem_addr 0, mem_wdata 0, l2_load_value 0, index 0, watchdog 0.
- Asynchronous reset mid-transfer: strobes drop immediately and the partial transfer is abandoned. No recovery.
- Request sampled at edge k → L2_BUSY and the first strobe from cycle k+1. Strobes come from registered state; address and data are mux outputs of registers.
- Zero-wait memory: BLOCK_SIZE_WORDS cycles in XFER, then L2_ACCESS. Total request-to-ACCESS latency is BLOCK_SIZE_WORDS+1 cycles.
- Each busy cycle adds exactly one cycle.
- The strobe stays high across consecutive words with no bubble.
- The error path asserts L2_ERROR on the cycle after the watchdog reaches TIMEOUT; strobes low that same cycle.

## Structure
- l2_state_t enum lives in the shared bus package used by the bus controller. Add it there if it is absent.
- Derived constants stay local: BLOCK_BYTES, OFFSET_W, IDX_W = max(1, $clog2(BLOCK_SIZE_WORDS)).
- Sub-module bus_watchdog: saturating counter with clear, increment and an expired flag (parameter TIMEOUT).

## Test plan
- Load addr 0x0000_1004, busy=0, rdata 0xAAAA_0000 then 0xBBBB_0001 → mem_addr 0x1000 then 0x1004; ACCESS on cycle 3; l2_load_value = 0xBBBB_0001_AAAA_0000.
- Store addr 0x2000, value 0x2222_2222_1111_1111, busy high 3 cycles on word 0 → wen held; writes 0x1111_1111 @0x2000 then 0x2222_2222 @0x2004; ACCESS after 5 cycles.
- Load and store high together in IDLE → L2_ERROR next cycle, no strobes; both dropped → L2_FREE.
- busy stuck high, TIMEOUT=25 → L2_ERROR after 25 busy cycles, ren low.
- Reset asserted during word 1 of a load → outputs at reset values asynchronously. A new load after reset completes normally.
- Request held 4 cycles in ACCESS → stays L2_ACCESS with no new strobes. Drop request, then immediate new load → FREE for one cycle, then BUSY.
